// File: rtl/fetch_redirect_stage.sv
// IF stage: program counter and IF/ID pipeline register.
// Redirects on a taken branch or jump from ID and inserts one bubble.
module fetch_redirect_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        Take_Branch,
    input  logic [31:0] Branch_Target,
    input  logic        Jump,
    input  logic [31:0] Jump_Target,
    input  logic [31:0] Instr_In,
    output logic [31:0] PC_Out,
    output logic [31:0] IFID_Instr,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        Flush
);

    localparam logic [31:0] WordMask = 32'hFFFF_FFFC;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Take_Branch is meaningless unless a branch actually sits in ID.
    assign redirect = Jump | (Branch & Take_Branch);
    assign target   = Jump ? Jump_Target : Branch_Target;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        flush_d = 1'b0;
        // Under a stall the comparator operands are stale, so redirects wait.
        if (!Stall) begin
            if (redirect) begin
                pc_d    = target & WordMask;
                instr_d = NOP_INSTR;
                pcp4_d  = 32'd0;
                valid_d = 1'b0;
                flush_d = 1'b1;
            end else begin
                pc_d    = pc_plus4;
                instr_d = Instr_In;
                pcp4_d  = pc_plus4;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q    <= RESET_PC & WordMask;
            instr_q <= NOP_INSTR;
            pcp4_q  <= 32'd0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
        end
    end

    assign PC_Out       = pc_q;
    assign IFID_Instr   = instr_q;
    assign IFID_PCPlus4 = pcp4_q;
    assign IFID_Valid   = valid_q;
    assign Flush        = flush_q;

endmodule

// File: tb/tb_fetch_redirect_stage.sv
// Directed bench for fetch_redirect_stage with an expected-state scoreboard.
module tb_fetch_redirect_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] MEM_KEY = 32'h5A5A_0000;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Stall, Branch, Take_Branch, Jump;
    logic [31:0] Branch_Target, Jump_Target, Instr_In;
    logic [31:0] PC_Out, IFID_Instr, IFID_PCPlus4;
    logic        IFID_Valid, Flush;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        valid;
        logic        flush;
    } exp_t;

    exp_t sb[$];

    fetch_redirect_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Stall         (Stall),
        .Branch        (Branch),
        .Take_Branch   (Take_Branch),
        .Branch_Target (Branch_Target),
        .Jump          (Jump),
        .Jump_Target   (Jump_Target),
        .Instr_In      (Instr_In),
        .PC_Out        (PC_Out),
        .IFID_Instr    (IFID_Instr),
        .IFID_PCPlus4  (IFID_PCPlus4),
        .IFID_Valid    (IFID_Valid),
        .Flush         (Flush)
    );

    always #5 Clk = ~Clk;

    // Combinational instruction memory: each word is its address tagged with a key.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ MEM_KEY;
    endfunction

    assign Instr_In = mem(PC_Out);

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] pcp4, input logic valid, input logic flush);
        exp_t e;
        e.pc = pc; e.instr = instr; e.pcp4 = pcp4; e.valid = valid; e.flush = flush;
        sb.push_back(e);
    endtask

    task automatic check_now(input string tag, input exp_t e);
        cmp({tag, ".pc"},    PC_Out,       e.pc);
        cmp({tag, ".instr"}, IFID_Instr,   e.instr);
        cmp({tag, ".pcp4"},  IFID_PCPlus4, e.pcp4);
        cmp({tag, ".valid"}, {31'd0, IFID_Valid}, {31'd0, e.valid});
        cmp({tag, ".flush"}, {31'd0, Flush},      {31'd0, e.flush});
    endtask

    // Advance one edge, then pop the oldest expectation and compare.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check_now(tag, e);
        end
    endtask

    task automatic drive(input logic st, input logic br, input logic tk, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt);
        Stall = st; Branch = br; Take_Branch = tk; Branch_Target = bt;
        Jump = jp; Jump_Target = jt;
    endtask

    initial begin
        exp_t rst_exp;
        rst_exp = '{pc: 32'h0, instr: NOP, pcp4: 32'h0, valid: 1'b0, flush: 1'b0};
        Reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #12;
        check_now("reset", rst_exp);
        #10 Reset_n = 1'b1;

        // 1: sequential fetch
        push(32'h4,  mem(32'h0), 32'h4,  1'b1, 1'b0); tick("seq0");
        push(32'h8,  mem(32'h4), 32'h8,  1'b1, 1'b0); tick("seq1");
        push(32'hC,  mem(32'h8), 32'hC,  1'b1, 1'b0); tick("seq2");
        push(32'h10, mem(32'hC), 32'h10, 1'b1, 1'b0); tick("seq3");

        // 2: taken branch at PC=0x10
        drive(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        push(32'h40, NOP, 32'h0, 1'b0, 1'b1); tick("br_taken");
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        push(32'h44, mem(32'h40), 32'h44, 1'b1, 1'b0); tick("br_after");

        // 3: jump back to 0x10, then branch not taken / take without branch
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
        push(32'h10, NOP, 32'h0, 1'b0, 1'b1); tick("jmp_10");
        drive(1'b0, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0);
        push(32'h14, mem(32'h10), 32'h14, 1'b1, 1'b0); tick("br_not_taken");
        drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        push(32'h18, mem(32'h14), 32'h18, 1'b1, 1'b0); tick("take_no_branch");

        // 4: stall holds against a pending redirect, then honours it
        drive(1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        push(32'h18, mem(32'h14), 32'h18, 1'b1, 1'b0); tick("stall0");
        push(32'h18, mem(32'h14), 32'h18, 1'b1, 1'b0); tick("stall1");
        drive(1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        push(32'h80, NOP, 32'h0, 1'b0, 1'b1); tick("stall_release");
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        push(32'h80, NOP, 32'h0, 1'b0, 1'b0); tick("stall_clears_flush");
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        push(32'h84, mem(32'h80), 32'h84, 1'b1, 1'b0); tick("resume");

        // 5: jump beats branch; misaligned target; back-to-back redirects
        drive(1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h200);
        push(32'h200, NOP, 32'h0, 1'b0, 1'b1); tick("jump_wins");
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h203);
        push(32'h200, NOP, 32'h0, 1'b0, 1'b1); tick("jump_misaligned");
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        push(32'h204, mem(32'h200), 32'h204, 1'b1, 1'b0); tick("after_jump");

        // 6: PC wrap, then asynchronous reset mid-cycle
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC, NOP, 32'h0, 1'b0, 1'b1); tick("jmp_top");
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        push(32'h0, mem(32'hFFFF_FFFC), 32'h0, 1'b1, 1'b0); tick("wrap");
        push(32'h4, mem(32'h0), 32'h4, 1'b1, 1'b0); tick("post_wrap");
        #2 Reset_n = 1'b0;
        #1 check_now("async_reset", rst_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
